// File: rtl/bin_to_ex3_seq.sv
// bin_to_ex3_seq: sequential double-dabble binary to BCD / Excess-3 converter, one bit per clock.
module bin_to_ex3_seq #(
  parameter int W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  input  logic                  mode,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   code,
  output logic                  ovf
);
  localparam int CW = 4 * DIGITS;
  localparam int NW = (W > 2) ? $clog2(W) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] OUT = 2'd2;
  logic [1:0]    state;
  logic [W-1:0]  sr;
  logic [CW-1:0] acc, adj, ex3;
  logic [NW-1:0] cnt;
  logic          mode_q, ovf_acc;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign adj[4*i+:4] = (acc[4*i+:4] >= 4'd5) ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
    assign ex3[4*i+:4] = acc[4*i+:4] + 4'd3;
  end
  assign ready = (state == IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      acc <= '0;
      cnt <= '0;
      mode_q <= 1'b0;
      ovf_acc <= 1'b0;
      code <= '0;
      ovf <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sr <= bin;
          mode_q <= mode;
          acc <= '0;
          ovf_acc <= 1'b0;
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          {acc, sr} <= {adj, sr} << 1;
          ovf_acc <= ovf_acc | adj[CW-1];
          cnt <= cnt + NW'(1);
          if (cnt == NW'(W - 1)) state <= OUT;
        end
        OUT: begin
          code <= mode_q ? ex3 : acc;
          ovf <= ovf_acc;
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_ex3_seq.sv
// tb_bin_to_ex3_seq: directed and random checks of the converter against a decimal-arithmetic model.
module tb_bin_to_ex3_seq;
  logic        clk, rst, start, mode;
  logic [7:0]  bin;
  logic        ready3, valid3, ovf3, ready2, valid2, ovf2;
  logic [11:0] code3;
  logic [7:0]  code2;
  int          checks = 0, failures = 0;
  logic [8:0]  q[$];
  logic [8:0]  e;
  logic [11:0] held;
  int          cyc, last_t, n;
  bit          have_last;

  bin_to_ex3_seq #(.W(8), .DIGITS(3)) dut3 (.clk(clk), .rst(rst), .start(start), .bin(bin), .mode(mode),
    .ready(ready3), .valid(valid3), .code(code3), .ovf(ovf3));
  bin_to_ex3_seq #(.W(8), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .start(start), .bin(bin), .mode(mode),
    .ready(ready2), .valid(valid2), .code(code2), .ovf(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p *= 10;
    return p;
  endfunction

  function automatic logic [31:0] ref_code(input int v, input int m, input int d);
    int x = v % pow10(d);
    logic [31:0] c = '0;
    for (int i = 0; i < d; i++) begin
      c |= 32'((x % 10) + (m != 0 ? 3 : 0)) << (4 * i);
      x /= 10;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [7:0] b, input logic m);
    int k;
    chk("ready_before", 32'(ready3), 1);
    bin = b; mode = m; start = 1'b1;
    tick();
    start = 1'b0; bin = 8'($urandom); mode = 1'($urandom);
    chk("busy", 32'(ready3), 0);
    k = 0;
    while (!valid3 && k < 20) begin
      tick();
      k++;
      if (!valid3 && k < 9) begin
        start = 1'b1;
        bin = 8'($urandom);
      end else start = 1'b0;
    end
    start = 1'b0;
    chk("latency", k, 9);
    chk("code3", 32'(code3), ref_code(int'(b), int'(m), 3));
    chk("ovf3", 32'(ovf3), 32'(int'(b) >= 1000));
    chk("valid2", 32'(valid2), 1);
    chk("code2", 32'(code2), ref_code(int'(b), int'(m), 2));
    chk("ovf2", 32'(ovf2), 32'(int'(b) >= 100));
    chk("ready_in_valid", 32'(ready3), 1);
    tick();
    chk("valid_pulse", 32'(valid3), 0);
    chk("code_hold", 32'(code3), ref_code(int'(b), int'(m), 3));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0; mode = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(ready3), 1);
    chk("rst_valid", 32'(valid3), 0);
    chk("rst_code", 32'(code3), 0);
    chk("rst_ovf", 32'(ovf3), 0);
    rst = 1'b0;
    tick();
    run(8'd0, 1'b1);
    run(8'd255, 1'b0);
    run(8'd255, 1'b1);
    chk("vec_588", 32'(code3), 32'h588);
    run(8'd85, 1'b1);
    run(8'd128, 1'b1);
    run(8'd204, 1'b1);
    run(8'd15, 1'b1);
    chk("vec_348", 32'(code3), 32'h348);
    run(8'd99, 1'b0);
    chk("vec_d2_99", 32'(code2), 32'h99);
    repeat (20) run(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    // streaming: start held high, a new operand each cycle; only idle-cycle operands are taken
    start = 1'b1; cyc = 0; have_last = 0;
    held = code3;
    repeat (60) begin
      if (valid3) begin
        e = q.pop_front();
        chk("stream_code", 32'(code3), ref_code(int'(e[7:0]), int'(e[8]), 3));
        chk("stream_ovf2", 32'(ovf2), 32'(int'(e[7:0]) >= 100));
        if (have_last) chk("stream_interval", cyc - last_t, 10);
        last_t = cyc; have_last = 1; held = code3;
      end else chk("stream_stable", 32'(code3), 32'(held));
      bin = 8'($urandom); mode = 1'($urandom);
      if (ready3) q.push_back({mode, bin});
      tick();
      cyc++;
    end
    start = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      if (valid3) begin
        e = q.pop_front();
        chk("drain_code", 32'(code3), ref_code(int'(e[7:0]), int'(e[8]), 3));
      end else begin
        tick();
        n++;
      end
    end
    chk("drain_done", q.size(), 0);
    tick(); tick();
    // abort a conversion with reset
    bin = 8'd200; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", 32'(ready3), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(ready3), 1);
    chk("abort_valid", 32'(valid3), 0);
    chk("abort_code3", 32'(code3), 0);
    chk("abort_ovf3", 32'(ovf3), 0);
    chk("abort_code2", 32'(code2), 0);
    n = 0;
    repeat (12) begin
      tick();
      if (valid3) n++;
    end
    chk("abort_no_valid", n, 0);
    run(8'd7, 1'b1);
    chk("vec_33a", 32'(code3), 32'h33A);
    // reset and start on the same edge: reset wins
    rst = 1'b1; start = 1'b1; bin = 8'd50;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    chk("rst_wins", 32'(ready3), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bin_to_ex3_seq.md
# bin_to_ex3_seq

Sequential, parametrised binary-to-Excess-3 converter. It converts a W-bit unsigned binary word into DIGITS decimal digits using shift-and-add-3 (double dabble), one bit per clock. Each digit is emitted either as plain BCD or as Excess-3 (digit + 3), chosen per conversion. It supersedes the fixed 8-bit "add 3" combinational converter in the code-conversion library, and takes a start/ready/valid handshake from the surrounding datapath.

## Interface
- W, default 8: binary input width (≥ 2).
- DIGITS, default 3: decimal digits produced (≥ 1). Insufficient DIGITS is legal and flagged via ovf.
- CW, derived (4*DIGITS): output code width. Not user-set.

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request; accepted only when ready=1
- bin  in  W  unsigned binary operand; sampled on the accepting edge
- mode  in  1  0 = BCD output, 1 = Excess-3 output; sampled with bin
- ready  out  1  1 = idle, can accept start
- valid  out  1  one-cycle pulse when code/ovf are updated
- code  out  CW  result; digit i in bits [4i+3:4i], i=0 least significant
- ovf  out  1  1 = value ≥ 10^DIGITS; code holds value mod 10^DIGITS

## Operation
- States:
  - IDLE: ready=1.
  - SHIFT: W iterations, ready=0.
  - OUT: one cycle, ready=0.
- IDLE, start=1 → SHIFT:
  - Capture bin into shift register sr, and mode into mode_q.
  - Clear the BCD accumulator acc (CW bits), ovf_acc and the iteration counter.
- SHIFT, one iteration per edge:
  - Every acc digit ≥ 5 gets +3 (4-bit, no carry).
  - Shift {acc, sr} left by 1.
  - ovf_acc |= bit shifted out of acc MSB.
  - After W iterations → OUT.
- OUT → IDLE:
  - code ← acc with each digit +3 if mode_q=1, else acc unchanged.
  - ovf ← ovf_acc; valid ← 1.
- Excess-3 digits lie in 3..12 (0x3..0xC). No inter-digit carry.
- With overflow, code is still the correct low DIGITS digits (mod 10^DIGITS); ovf=1.
- start while ready=0 is ignored. Changes to bin or mode after acceptance have no effect.
- code and ovf hold their values until the next OUT; they are not cleared by a new start.
- Reset values: state IDLE, ready=1, valid=0, code=0, ovf=0. Internal sr, acc and counter are cleared.
- rst asserted in any state aborts the conversion. No valid is produced, and code/ovf return to 0.

## Timing
- Start accepted at edge E0. SHIFT iterations occur at edges E1..EW. OUT occurs at edge EW+1.
- ready is low from after E0 until EW+1. valid and the new code/ovf are visible in the cycle after EW+1 (latency W+1 cycles).
- valid is high for exactly one cycle. ready=1 in that same cycle.
- start may be high in the valid cycle and is accepted there. Maximum throughput is one result per W+2 cycles with start held high.
- rst and start on the same edge: rst wins.

## Test plan
- W=8, DIGITS=3, bin=0, mode=1 → valid 9 cycles after acceptance; code=0x333, ovf=0.
- W=8, DIGITS=3, bin=255:
  - mode=0 → code=0x255, ovf=0.
  - mode=1 → code=0x588.
- W=8, DIGITS=3, mode=1:
  - bin=85 → 0x3B8.
  - bin=128 → 0x45B.
  - bin=204 → 0x537.
  - bin=15 → 0x348.
- W=8, DIGITS=2, bin=255:
  - mode=0 → code=0x55, ovf=1.
  - bin=99 → code=0x99, ovf=0.
- Start held high, bin changed every cycle:
  - Only values sampled when ready=1 are converted.
  - Results arrive every 10 cycles.
  - code stays stable between valid pulses.
- rst pulsed 4 cycles into a conversion of bin=200:
  - No valid; code=0, ovf=0, ready=1 the cycle after rst.
  - A new start with bin=7, mode=1 → code=0x33A.
